// File: rtl/chunk_adder_seq.sv
// chunk_adder_seq
//   Multi-cycle WIDTH-bit adder/subtractor. Each operation is split into
//   NCHUNK = WIDTH/CHUNK slices. A CHUNK-bit ripple-carry stage handles one
//   slice per clock, so the critical carry chain is only CHUNK bits long.
//
//   Handshake rule: a transfer happens on a rising clk edge where both valid
//   and ready are high. in_ready is high only in IDLE and out_valid only in
//   DONE. Both are decoded from the registered state, so neither depends
//   combinationally on any input.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept operands (state == IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result available (state == DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result, held until the next result is produced
//   cout       carry-out; in subtract mode 1 means no borrow
//   ovf        two's-complement signed overflow
//
// The register 'state' is kept as a named signal so that checkers can bind
// to it directly.
module chunk_adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK    = WIDTH'({CHUNK{1'b1}});

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] r_ch;
  logic [CHUNK:0]   rc;
  logic             c_next;
  logic             c_msb;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (idx == LAST_IDX);

  // One CHUNK-bit ripple stage. The current slice is selected by shifting
  // rather than by a variable part-select, which keeps the index widths clean.
  always_comb begin
    shamt    = 32'(idx) * CHUNK;
    a_sh     = opa >> shamt;
    b_sh     = opb >> shamt;
    a_ch     = a_sh[CHUNK-1:0];
    b_ch     = b_sh[CHUNK-1:0];
    rc       = '0;
    rc[0]    = carry;
    r_ch     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      r_ch[i]  = a_ch[i] ^ b_ch[i] ^ rc[i];
      rc[i+1]  = (a_ch[i] & b_ch[i]) | (rc[i] & (a_ch[i] ^ b_ch[i]));
    end
    c_next   = rc[CHUNK];
    // On the last slice this is the carry into bit WIDTH-1, used for ovf.
    c_msb    = rc[CHUNK-1];
    acc_next = (acc & ~(CMASK << shamt)) | (WIDTH'(r_ch) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~cin. This form gives a-b-cin, and
            // cout=1 means no borrow.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c_next;
          idx   <= idx + 1'b1;
          if (last) begin
            sum   <= acc_next;
            cout  <= c_next;
            ovf   <= c_next ^ c_msb;
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_adder_seq.sv
module tb_chunk_adder_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  cin_v;
  logic [2:0]  sub_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [15:0] a_v   [3];
  logic [15:0] b_v   [3];
  logic [15:0] sum_v [3];

  int tests_run;
  int tests_failed;

  // Three instances: CHUNK = 4, 16 and 1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    chunk_adder_seq #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .cin       (cin_v[g]),
      .sub       (sub_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .sum       (sum_v[g]),
      .cout      (cout_v[g]),
      .ovf       (ovf_v[g])
    );
  end

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [7];

  // Scoreboard: expected results are queued when an operation is issued and
  // popped when the result is read.
  logic [17:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int c);
    return (c == 0) ? 4 : ((c == 1) ? 1 : 16);
  endfunction

  // Reference model built from integer arithmetic: {sum, cout, ovf}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    int ua, ub, sa, sb, u, r, ci;
    logic [15:0] s;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (!sub) begin
      u  = ua + ub + ci;
      co = (u > 65535);
      r  = sa + sb + ci;
    end else begin
      u  = ua - ub - ci;
      co = (ua >= ub + ci);
      r  = sa - sb - ci;
    end
    s  = u[15:0];
    ov = (r > 32767) || (r < -32768);
    return {s, co, ov};
  endfunction

  // Driver: issue one op on instance c, then wait for and consume the result.
  task automatic do_op(input int c, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic cin_i, input logic sub_i,
                       output logic [15:0] s, output logic co, output logic ov,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready_v[c] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("in_ready_wait", 32'(in_ready_v[c]), 32'd1);
    a_v[c]        = a_i;
    b_v[c]        = b_i;
    cin_v[c]      = cin_i;
    sub_v[c]      = sub_i;
    in_valid_v[c] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[c] = 1'b0;
    // Scramble the operands after acceptance. This must not affect the op.
    a_v[c]   = 16'($urandom_range(0, 65535));
    b_v[c]   = 16'($urandom_range(0, 65535));
    cin_v[c] = ~cin_i;
    sub_v[c] = ~sub_i;
    lat = 0;
    while (!out_valid_v[c] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s  = sum_v[c];
    co = cout_v[c];
    ov = ovf_v[c];
    @(negedge clk);
    out_ready_v[c] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[c] = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic        co, ov;
    logic [17:0] e;
    int          lat;
    int          guard;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid_v   = '0;
    out_ready_v  = '0;
    cin_v        = '0;
    sub_v        = '0;
    for (int c = 0; c < 3; c++) begin
      a_v[c] = '0;
      b_v[c] = '0;
    end

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("rst_in_ready",  32'(in_ready_v[c]),  32'd1);
      check("rst_out_valid", 32'(out_valid_v[c]), 32'd0);
      check("rst_sum",       32'(sum_v[c]),       32'd0);
      check("rst_cout",      32'(cout_v[c]),      32'd0);
      check("rst_ovf",       32'(ovf_v[c]),       32'd0);
    end

    // Directed vector table applied to every configuration
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 7; i++) begin
        exp_q.push_back({vecs[i].s, vecs[i].co, vecs[i].ov});
        do_op(c, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
        e = exp_q.pop_front();
        check("vec_sum",  32'(s),  32'(e[17:2]));
        check("vec_cout", 32'(co), 32'(e[1]));
        check("vec_ovf",  32'(ov), 32'(e[0]));
        check("vec_latency", 32'(lat), 32'(lat_of(c)));
      end
    end

    // Backpressure, and in_valid pulses while busy (CHUNK=4 instance)
    @(negedge clk);
    a_v[0] = 16'h7FFF; b_v[0] = 16'h0001; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    check("bp_in_ready_run", 32'(in_ready_v[0]), 32'd0);
    @(negedge clk);
    a_v[0] = 16'h1111; b_v[0] = 16'h2222; in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_run2", 32'(in_ready_v[0]), 32'd0);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    guard = 0;
    while (!out_valid_v[0] && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_reach_done", 32'(out_valid_v[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
      check("bp_in_ready",  32'(in_ready_v[0]),  32'd0);
      check("bp_sum",       32'(sum_v[0]),       32'h8000);
      check("bp_cout",      32'(cout_v[0]),      32'd0);
      check("bp_ovf",       32'(ovf_v[0]),       32'd1);
    end
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    check("bp_release_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("bp_release_in_ready",  32'(in_ready_v[0]),  32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("bp_idle_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("bp_idle_sum_held",  32'(sum_v[0]),       32'h8000);
    end

    // Asynchronous reset two cycles into RUN
    @(negedge clk);
    a_v[0] = 16'h1234; b_v[0] = 16'h4321; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("abort_sum",       32'(sum_v[0]),       32'd0);
    check("abort_in_ready",  32'(in_ready_v[0]),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("abort_no_stale_valid", 32'(out_valid_v[0]), 32'd0);
    end
    do_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, s, co, ov, lat);
    check("after_abort_sum", 32'(s),   32'h0007);
    check("after_abort_lat", 32'(lat), 32'd4);

    // Random vectors against the reference model, every configuration
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 200; i++) begin
        logic [15:0] ra, rb;
        logic        rci, rsub;
        ra   = 16'($urandom_range(0, 65535));
        rb   = 16'($urandom_range(0, 65535));
        rci  = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        exp_q.push_back(ref_op(ra, rb, rci, rsub));
        do_op(c, ra, rb, rci, rsub, s, co, ov, lat);
        e = exp_q.pop_front();
        check("rand_result",  {14'd0, s, co, ov}, {14'd0, e});
        check("rand_latency", 32'(lat), 32'(lat_of(c)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
